// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback formatter feeding the register file write port.
// Optional retire counter output is enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_to_reg,
    input  logic [2:0]  mem_load_type,
    input  logic [1:0]  mem_byte_off,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_read_data,
    input  logic [4:0]  mem_w_addr,
    output logic        reg_write,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        wb_valid,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0] retire_count,
`endif
    output logic        wb_misalign
);

    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] off);
        logic [1:0] idx;
        if (BIG_ENDIAN) begin
            idx = 2'd3 - off;
        end else begin
            idx = off;
        end
        return word[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] pick_half(input logic [31:0] word, input logic off_hi);
        logic idx;
        if (BIG_ENDIAN) begin
            idx = ~off_hi;
        end else begin
            idx = off_hi;
        end
        return word[{idx, 4'b0000} +: 16];
    endfunction

    logic [31:0] fmt_data_s;
    logic        misalign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        capture_s;

    logic        reg_write_q, reg_write_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        wb_valid_q, wb_valid_d;
    logic        misalign_q, misalign_d;

    // Load lane extraction and extension; misaligned loads pass the raw word through.
    always_comb begin
        fmt_data_s = mem_alu_result;
        misalign_s = 1'b0;
        byte_s     = pick_byte(mem_read_data, mem_byte_off);
        half_s     = pick_half(mem_read_data, mem_byte_off[1]);
        if (mem_to_reg) begin
            case (mem_load_type)
                LT_LH, LT_LHU: begin
                    if (mem_byte_off[0]) begin
                        misalign_s = 1'b1;
                        fmt_data_s = mem_read_data;
                    end else if (mem_load_type == LT_LH) begin
                        fmt_data_s = {{16{half_s[15]}}, half_s};
                    end else begin
                        fmt_data_s = {16'h0000, half_s};
                    end
                end
                LT_LB: fmt_data_s = {{24{byte_s[7]}}, byte_s};
                LT_LBU: fmt_data_s = {24'h000000, byte_s};
                default: begin
                    fmt_data_s = mem_read_data;
                    misalign_s = (mem_byte_off != 2'd0);
                end
            endcase
        end else begin
            fmt_data_s = mem_alu_result;
        end
    end

    // Next-state selection: flush bubbles even when stalled, stall holds, otherwise capture.
    always_comb begin
        reg_write_d = reg_write_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        wb_valid_d  = wb_valid_q;
        misalign_d  = misalign_q;
        capture_s   = 1'b0;
        if (flush) begin
            reg_write_d = 1'b0;
            w_addr_d    = 5'd0;
            w_data_d    = 32'd0;
            wb_valid_d  = 1'b0;
            misalign_d  = 1'b0;
        end else if (stall) begin
            capture_s = 1'b0;
        end else begin
            capture_s   = 1'b1;
            wb_valid_d  = mem_valid;
            w_addr_d    = mem_w_addr;
            w_data_d    = fmt_data_s;
            misalign_d  = mem_valid & misalign_s;
            reg_write_d = mem_valid & mem_reg_write & (mem_w_addr != 5'd0) & ~misalign_s;
        end
    end

    // WB pipeline register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            w_addr_q    <= 5'd0;
            w_data_q    <= 32'd0;
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            wb_valid_q  <= wb_valid_d;
            misalign_q  <= misalign_d;
        end
    end

    assign reg_write   = reg_write_q;
    assign w_addr      = w_addr_q;
    assign w_data      = w_data_q;
    assign wb_valid    = wb_valid_q;
    assign wb_misalign = misalign_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Count cleanly retiring instructions; wraps naturally at 32 bits.
    always_comb begin
        if (capture_s & mem_valid & ~misalign_s) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed spec vectors plus randomized traffic
// checked against a behavioural reference model (big-endian lane order).
module tb_wb_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic        mem_valid, mem_reg_write, mem_to_reg;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_byte_off;
    logic [31:0] mem_alu_result, mem_read_data;
    logic [4:0]  mem_w_addr;
    logic        reg_write, wb_valid, wb_misalign;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
    logic [31:0] exp_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // reference model state
    logic        exp_we, exp_valid, exp_mis;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    wb_stage #(.BIG_ENDIAN(1'b1)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
        .mem_load_type(mem_load_type), .mem_byte_off(mem_byte_off),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_w_addr(mem_w_addr), .reg_write(reg_write), .w_addr(w_addr),
        .w_data(w_data), .wb_valid(wb_valid),
`ifdef WB_RETIRE_CNT_EN
        .retire_count(retire_count),
`endif
        .wb_misalign(wb_misalign)
    );

    always #5 clock = ~clock;

    function automatic logic [39:0] observed();
        return {reg_write, w_addr, w_data, wb_valid, wb_misalign};
    endfunction

    function automatic logic [39:0] expected();
        return {exp_we, exp_addr, exp_data, exp_valid, exp_mis};
    endfunction

    // Returns {misalign, data} computed from the load rules with plain arithmetic.
    function automatic logic [32:0] ref_fmt(input logic to_reg, input logic [2:0] lt,
                                            input logic [1:0] off, input logic [31:0] alu,
                                            input logic [31:0] rd);
        logic [31:0] v;
        int o;
        o = int'(off);
        if (!to_reg) return {1'b0, alu};
        if (lt == 3'd1 || lt == 3'd2) begin
            if (o % 2 == 1) return {1'b1, rd};
            v = (rd >> (o == 0 ? 16 : 0)) & 32'h0000FFFF;
            if (lt == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
            return {1'b0, v};
        end
        if (lt == 3'd3 || lt == 3'd4) begin
            v = (rd >> (24 - 8 * o)) & 32'h000000FF;
            if (lt == 3'd3 && v >= 32'h80) v = v | 32'hFFFFFF00;
            return {1'b0, v};
        end
        return {(o != 0), rd};
    endfunction

    task automatic model_reset();
        exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_valid = 1'b0; exp_mis = 1'b0;
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = 32'd0;
`endif
    endtask

    task automatic model_edge();
        logic [32:0] r;
        if (flush) begin
            exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_valid = 1'b0; exp_mis = 1'b0;
        end else if (!stall) begin
            r = ref_fmt(mem_to_reg, mem_load_type, mem_byte_off, mem_alu_result, mem_read_data);
            exp_valid = mem_valid;
            exp_addr  = mem_w_addr;
            exp_data  = r[31:0];
            exp_mis   = mem_valid && r[32];
            exp_we    = mem_valid && mem_reg_write && (mem_w_addr != 5'd0) && !r[32];
`ifdef WB_RETIRE_CNT_EN
            if (mem_valid && !r[32]) exp_cnt = exp_cnt + 32'd1;
`endif
        end
    endtask

    task automatic set_in(input logic v, input logic rw, input logic tr, input logic [2:0] lt,
                          input logic [1:0] off, input logic [31:0] alu, input logic [31:0] rd,
                          input logic [4:0] wa, input logic st, input logic fl);
        mem_valid = v; mem_reg_write = rw; mem_to_reg = tr; mem_load_type = lt;
        mem_byte_off = off; mem_alu_result = alu; mem_read_data = rd; mem_w_addr = wa;
        stall = st; flush = fl;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h12345678, 32'h0, 5'd7, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clock);
        checks++;
        if (observed() !== 40'h0) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", observed(), 40'h0);
        end
        reset = 1'b0;
    endtask

    task automatic test_loads();
        // lt, off, to_reg, alu, rd, wa, want_data, want_we, want_mis
        logic [2:0]  lt_t [10] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
        logic [1:0]  of_t [10] = '{2'd0, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0};
        logic        tr_t [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0]  wa_t [10] = '{5'd5, 5'd5, 5'd6, 5'd7, 5'd8, 5'd0, 5'd31, 5'd9, 5'd10, 5'd11};
        logic [31:0] dd_t [10] = '{32'hFFFFFF80, 32'h00000034, 32'hFFFF80FF, 32'h00001234,
                                   32'h80FF1234, 32'hDEADBEEF, 32'hDEADBEEF, 32'h80FF1234,
                                   32'hFFFFFFFF, 32'h80FF1234};
        logic        we_t [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        mi_t [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [39:0] want;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 1'b1, tr_t[i], lt_t[i], of_t[i], 32'hDEADBEEF, 32'h80FF1234,
                   wa_t[i], 1'b0, 1'b0);
            cycle();
            want = {we_t[i], wa_t[i], dd_t[i], 1'b1, mi_t[i]};
            checks++;
            if (observed() !== want) begin
                failures++;
                $display("FAIL load_vec%0d got=%h want=%h", i, observed(), want);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [39:0] held;
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFEF00D, 32'h0, 5'd12, 1'b0, 1'b0);
        cycle();
        held = {1'b1, 5'd12, 32'hCAFEF00D, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, $urandom, $urandom, 5'($urandom), 1'b1, 1'b0);
            cycle();
            checks++;
            if (observed() !== held) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h want=%h", i, observed(), held);
            end
        end
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h11111111, 32'h0, 5'd3, 1'b1, 1'b1);
        cycle();
        checks++;
        if (observed() !== 40'h0) begin
            failures++;
            $display("FAIL flush_with_stall got=%h want=%h", observed(), 40'h0);
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'hA5000000, 5'd20, 1'b0, 1'b0);
        cycle();
        checks++;
        if (observed() !== {1'b1, 5'd20, 32'h000000A5, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL pre_reset_capture got=%h", observed());
        end
        #1 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (observed() !== 40'h0) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", observed(), 40'h0);
        end
        #1 reset = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'h0000C001, 5'd21, 1'b0, 1'b0);
        cycle();
        checks++;
        if (observed() !== {1'b1, 5'd21, 32'hFFFFC001, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_capture got=%h", observed());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                   3'($urandom_range(0, 7)), 2'($urandom), $urandom,
                   ($urandom_range(0, 1) != 0) ? $urandom : 32'h80FF7F01,
                   5'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            cycle();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL random%0d got=%h want=%h", i, observed(), expected());
            end
`ifdef WB_RETIRE_CNT_EN
            checks++;
            if (retire_count !== exp_cnt) begin
                failures++;
                $display("FAIL random_cnt%0d got=%h want=%h", i, retire_count, exp_cnt);
            end
`endif
        end
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire_count();
        @(negedge clock) reset = 1'b1;
        model_reset();
        @(negedge clock) reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 1'b1, 3'd3, 2'(i), 32'h0, 32'h01020304, 5'd4, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h5, 32'h0, 5'd4, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h5, 32'h0, 5'd4, 1'b0, 1'b1);
        cycle();
        set_in(1'b1, 1'b1, 1'b1, 3'd0, 2'd1, 32'h0, 32'h5, 5'd4, 1'b0, 1'b0);
        cycle();
        checks++;
        if (retire_count !== 32'd4) begin
            failures++;
            $display("FAIL retire_count got=%h want=%h", retire_count, 32'd4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_stall_flush();
        test_async_reset();
        test_random();
`ifdef WB_RETIRE_CNT_EN
        test_retire_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
